id_ex_stage: RTL and testbench

ID/EX pipeline stage that registers decoded instructions and presents final operands and the operation code to the combinational ALU. It applies EX/MEM and MEM/WB forwarding, selects PC or immediate operands, detects load-use hazards, and inserts bubbles on hazard or flush. It sits between the decode stage and the ALU; its outputs drive the ALU's `rs1_value`, `rs2_value` and `alu_operation` inputs directly.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/id_ex_stage_if.sv | 39 +++
 rtl/operand_forward.sv | 30 +++
 rtl/id_ex_stage.sv | 141 ++++++++++++++
 tb/tb_id_ex_stage.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV pipeline definitions: ALU operation codes and default widths.
package rv_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_RA_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1101
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode -> ID/EX handshake bundle.
//   master: decode side, drives the decoded instruction, sees ready.
//   slave : ID/EX stage side, consumes the instruction, drives ready.
interface id_ex_stage_if #(
  parameter int XLEN = rv_pkg::DEF_XLEN,
  parameter int RA_W = rv_pkg::DEF_RA_W
);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [RA_W-1:0] rs1_addr;
  logic [RA_W-1:0] rs2_addr;
  logic [RA_W-1:0] rd_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_used;
  logic            rs2_used;
  logic            use_pc;
  logic            use_imm;
  logic [3:0]      alu_op;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;

  modport master (
    output valid, pc, imm, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data,
           rs1_used, rs2_used, use_pc, use_imm, alu_op, reg_write, mem_read,
           mem_write,
    input  ready
  );

  modport slave (
    input  valid, pc, imm, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data,
           rs1_used, rs2_used, use_pc, use_imm, alu_op, reg_write, mem_read,
           mem_write,
    output ready
  );
endinterface

// File: rtl/operand_forward.sv
// Per-source forwarding mux: EX/MEM result beats MEM/WB result beats the
// registered register-file data. x0 never forwards.
//   addr/raw        : registered source index and raw read data
//   exm_* / mwb_*   : forwarding sources (write enable, dest, value)
//   value           : forwarded operand
module operand_forward #(
  parameter int XLEN = rv_pkg::DEF_XLEN,
  parameter int RA_W = rv_pkg::DEF_RA_W
) (
  input  logic [RA_W-1:0] addr,
  input  logic [XLEN-1:0] raw,
  input  logic            exm_reg_write,
  input  logic [RA_W-1:0] exm_rd_addr,
  input  logic [XLEN-1:0] exm_value,
  input  logic            mwb_reg_write,
  input  logic [RA_W-1:0] mwb_rd_addr,
  input  logic [XLEN-1:0] mwb_value,
  output logic [XLEN-1:0] value
);
  always_comb begin
    value = raw;
    if (addr != '0) begin
      if (exm_reg_write && (exm_rd_addr == addr)) begin
        value = exm_value;
      end else if (mwb_reg_write && (mwb_rd_addr == addr)) begin
        value = mwb_value;
      end
    end
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Registers the decoded instruction, forwards
// operands from EX/MEM and MEM/WB, applies PC/immediate operand select,
// detects load-use hazards and inserts bubbles on hazard or flush.
//   clk, rst         : clock, synchronous active-high reset
//   id               : decode handshake bundle (slave side)
//   exm_* / mwb_*    : forwarding sources
//   stall, flush     : downstream freeze, kill of the EX instruction
//   load_use_hazard  : combinational hazard to fetch/decode
//   ex_*             : registered instruction and final ALU operands
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int RA_W = DEF_RA_W
) (
  input  logic            clk,
  input  logic            rst,
  id_ex_stage_if.slave    id,
  input  logic            exm_reg_write,
  input  logic [RA_W-1:0] exm_rd_addr,
  input  logic [XLEN-1:0] exm_value,
  input  logic            mwb_reg_write,
  input  logic [RA_W-1:0] mwb_rd_addr,
  input  logic [XLEN-1:0] mwb_value,
  input  logic            stall,
  input  logic            flush,
  output logic            load_use_hazard,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [XLEN-1:0] ex_rs1_value,
  output logic [XLEN-1:0] ex_rs2_value,
  output logic [3:0]      ex_alu_operation,
  output logic [XLEN-1:0] ex_store_data
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [RA_W-1:0] rd_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            use_pc;
    logic            use_imm;
    logic [3:0]      alu_op;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } ex_t;

  ex_t ex_d, ex_q;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // Bubble keeps data fields so the ALU inputs do not toggle needlessly.
  function automatic ex_t to_bubble(ex_t e);
    ex_t b;
    b           = e;
    b.valid     = 1'b0;
    b.reg_write = 1'b0;
    b.mem_read  = 1'b0;
    b.mem_write = 1'b0;
    return b;
  endfunction

  always_comb begin
    load_use_hazard = id.valid && ex_q.valid && ex_q.mem_read &&
                      (ex_q.rd_addr != '0) &&
                      ((id.rs1_used && (id.rs1_addr == ex_q.rd_addr)) ||
                       (id.rs2_used && (id.rs2_addr == ex_q.rd_addr)));
    id.ready = !stall && !load_use_hazard;
  end

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = to_bubble(ex_q);
    end else if (stall) begin
      ex_d = ex_q;
    end else if (load_use_hazard || !id.valid) begin
      ex_d = to_bubble(ex_q);
    end else begin
      ex_d.valid     = 1'b1;
      ex_d.pc        = id.pc;
      ex_d.imm       = id.imm;
      ex_d.rs1_addr  = id.rs1_addr;
      ex_d.rs2_addr  = id.rs2_addr;
      ex_d.rd_addr   = id.rd_addr;
      ex_d.rs1_data  = id.rs1_data;
      ex_d.rs2_data  = id.rs2_data;
      ex_d.use_pc    = id.use_pc;
      ex_d.use_imm   = id.use_imm;
      ex_d.alu_op    = id.alu_op;
      ex_d.reg_write = id.reg_write;
      ex_d.mem_read  = id.mem_read;
      ex_d.mem_write = id.mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      ex_q.alu_op <= ALU_ADD;
    end else begin
      ex_q <= ex_d;
    end
  end

  operand_forward #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .addr(ex_q.rs1_addr), .raw(ex_q.rs1_data),
    .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_value(exm_value),
    .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr), .mwb_value(mwb_value),
    .value(fwd_rs1)
  );

  operand_forward #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .addr(ex_q.rs2_addr), .raw(ex_q.rs2_data),
    .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_value(exm_value),
    .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr), .mwb_value(mwb_value),
    .value(fwd_rs2)
  );

  always_comb begin
    ex_valid         = ex_q.valid;
    ex_pc            = ex_q.pc;
    ex_rd_addr       = ex_q.rd_addr;
    ex_reg_write     = ex_q.reg_write;
    ex_mem_read      = ex_q.mem_read;
    ex_mem_write     = ex_q.mem_write;
    ex_alu_operation = ex_q.alu_op;
    ex_rs1_value     = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
    ex_rs2_value     = ex_q.use_imm ? ex_q.imm : fwd_rs2;
    ex_store_data    = fwd_rs2;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .RA_W(5)) id_bus ();

  logic        exm_reg_write, mwb_reg_write, stall, flush;
  logic [4:0]  exm_rd_addr, mwb_rd_addr;
  logic [31:0] exm_value, mwb_value;
  logic        load_use_hazard, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_pc, ex_rs1_value, ex_rs2_value, ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic [3:0]  ex_alu_operation;

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .id(id_bus),
    .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_value(exm_value),
    .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr), .mwb_value(mwb_value),
    .stall(stall), .flush(flush), .load_use_hazard(load_use_hazard),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_rs1_value(ex_rs1_value), .ex_rs2_value(ex_rs2_value),
    .ex_alu_operation(ex_alu_operation), .ex_store_data(ex_store_data)
  );

  typedef struct {
    bit rst, stall, flush, id_valid;
    logic [31:0] pc, imm, rs1d, rs2d;
    logic [4:0]  rs1a, rs2a, rda;
    bit rs1u, rs2u, use_pc, use_imm;
    logic [3:0]  op;
    bit rw, mr, mw;
    bit exm_we; logic [4:0] exm_rd; logic [31:0] exm_v;
    bit mwb_we; logic [4:0] mwb_rd; logic [31:0] mwb_v;
  } stim_t;

  // Instruction currently occupying EX, as the reference model sees it.
  typedef struct {
    bit valid;
    logic [31:0] pc, imm, rs1d, rs2d;
    logic [4:0]  rs1a, rs2a, rd;
    bit use_pc, use_imm;
    logic [3:0]  op;
    bit rw, mr, mw;
  } instr_t;

  typedef struct {
    bit valid, rw, mr, mw, hazard, ready;
    logic [31:0] pc, rs1, rs2, store;
    logic [4:0]  rd;
    logic [3:0]  op;
  } exp_t;

  typedef struct { bit we; logic [4:0] rd; logic [31:0] v; } src_t;

  exp_t   sb_q[$];
  instr_t model;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst      = ($urandom_range(0, 199) == 0);
    s.stall    = ($urandom_range(0, 4) == 0);
    s.flush    = ($urandom_range(0, 9) == 0);
    s.id_valid = ($urandom_range(0, 3) != 0);
    s.pc = $urandom; s.imm = $urandom; s.rs1d = $urandom; s.rs2d = $urandom;
    s.rs1a = 5'($urandom_range(0, 3)); s.rs2a = 5'($urandom_range(0, 3));
    s.rda  = 5'($urandom_range(0, 3));
    s.rs1u = 1'($urandom); s.rs2u = 1'($urandom);
    s.use_pc = 1'($urandom); s.use_imm = 1'($urandom);
    s.op = 4'($urandom);
    s.rw = 1'($urandom); s.mr = ($urandom_range(0, 2) == 0); s.mw = 1'($urandom);
    s.exm_we = 1'($urandom); s.exm_rd = 5'($urandom_range(0, 3)); s.exm_v = $urandom;
    s.mwb_we = 1'($urandom); s.mwb_rd = 5'($urandom_range(0, 3)); s.mwb_v = $urandom;
    return s;
  endfunction

  // A register read sees the newest in-flight write to it; x0 is never forwarded.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] raw,
                                          input stim_t s);
    src_t srcs[2];
    srcs[0] = '{s.exm_we, s.exm_rd, s.exm_v};
    srcs[1] = '{s.mwb_we, s.mwb_rd, s.mwb_v};
    if (r == 0) return raw;
    foreach (srcs[i]) if (srcs[i].we && srcs[i].rd == r) return srcs[i].v;
    return raw;
  endfunction

  function automatic bit id_reads(input stim_t s, input logic [4:0] r);
    return (s.rs1u && s.rs1a == r) || (s.rs2u && s.rs2a == r);
  endfunction

  function automatic bit hazard_of(input instr_t m, input stim_t s);
    return s.id_valid && m.valid && m.mr && (m.rd != 0) && id_reads(s, m.rd);
  endfunction

  function automatic exp_t expect_of(input instr_t m, input stim_t s);
    exp_t e;
    e.valid = m.valid; e.rw = m.rw; e.mr = m.mr; e.mw = m.mw;
    e.pc = m.pc; e.rd = m.rd; e.op = m.op;
    e.rs1   = m.use_pc  ? m.pc  : operand(m.rs1a, m.rs1d, s);
    e.store = operand(m.rs2a, m.rs2d, s);
    e.rs2   = m.use_imm ? m.imm : e.store;
    e.hazard = hazard_of(m, s);
    e.ready  = !s.stall && !e.hazard;
    return e;
  endfunction

  function automatic instr_t killed(input instr_t m);
    instr_t k = m;
    k.valid = 0; k.rw = 0; k.mr = 0; k.mw = 0;
    return k;
  endfunction

  function automatic instr_t next_of(input instr_t m, input stim_t s);
    instr_t n;
    if (s.rst) begin
      n = '{default: '0};
      return n;
    end
    if (s.flush) return killed(m);
    if (s.stall) return m;
    if (!s.id_valid || hazard_of(m, s)) return killed(m);
    n = '{valid: 1, pc: s.pc, imm: s.imm, rs1d: s.rs1d, rs2d: s.rs2d,
          rs1a: s.rs1a, rs2a: s.rs2a, rd: s.rda, use_pc: s.use_pc,
          use_imm: s.use_imm, op: s.op, rw: s.rw, mr: s.mr, mw: s.mw};
    return n;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; stall = s.stall; flush = s.flush;
    id_bus.valid = s.id_valid; id_bus.pc = s.pc; id_bus.imm = s.imm;
    id_bus.rs1_addr = s.rs1a; id_bus.rs2_addr = s.rs2a; id_bus.rd_addr = s.rda;
    id_bus.rs1_data = s.rs1d; id_bus.rs2_data = s.rs2d;
    id_bus.rs1_used = s.rs1u; id_bus.rs2_used = s.rs2u;
    id_bus.use_pc = s.use_pc; id_bus.use_imm = s.use_imm; id_bus.alu_op = s.op;
    id_bus.reg_write = s.rw; id_bus.mem_read = s.mr; id_bus.mem_write = s.mw;
    exm_reg_write = s.exm_we; exm_rd_addr = s.exm_rd; exm_value = s.exm_v;
    mwb_reg_write = s.mwb_we; mwb_rd_addr = s.mwb_rd; mwb_value = s.mwb_v;
  endtask

  // Inputs change on the falling edge; the expected view of this cycle is
  // queued, then the model advances to what the next rising edge produces.
  task automatic drive(input stim_t s);
    @(negedge clk);
    apply(s);
    sb_q.push_back(expect_of(model, s));
    model = next_of(model, s);
    #2;
  endtask

  // Monitor: compares every cycle's DUT view with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        cmp("ex_valid", 32'(ex_valid), 32'(e.valid));
        cmp("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
        cmp("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
        cmp("ex_mem_write", 32'(ex_mem_write), 32'(e.mw));
        cmp("load_use_hazard", 32'(load_use_hazard), 32'(e.hazard));
        cmp("id_ready", 32'(id_bus.ready), 32'(e.ready));
        cmp("ex_pc", ex_pc, e.pc);
        cmp("ex_rd_addr", 32'(ex_rd_addr), 32'(e.rd));
        cmp("ex_alu_operation", 32'(ex_alu_operation), 32'(e.op));
        cmp("ex_rs1_value", ex_rs1_value, e.rs1);
        cmp("ex_rs2_value", ex_rs2_value, e.rs2);
        cmp("ex_store_data", ex_store_data, e.store);
      end
    end
  end

  initial begin
    stim_t s, h;
    model = '{default: '0};
    s = idle(); s.rst = 1;
    apply(s);
    @(posedge clk);
    drive(s);
    cmp("reset_valid", 32'(ex_valid), 32'd0);
    cmp("reset_op", 32'(ex_alu_operation), 32'(ALU_ADD));
    cmp("reset_rs1", ex_rs1_value, 32'd0);

    // Plain issue
    s = idle(); s.id_valid = 1; s.op = ALU_ADD; s.rs1a = 1; s.rs1d = 5;
    s.rs2a = 2; s.rs2d = 7; s.rs1u = 1; s.rs2u = 1; s.rda = 3; s.rw = 1; s.pc = 32'h40;
    drive(s);
    drive(idle());
    cmp("plain_valid", 32'(ex_valid), 32'd1);
    cmp("plain_rs1", ex_rs1_value, 32'd5);
    cmp("plain_rs2", ex_rs2_value, 32'd7);
    cmp("plain_op", 32'(ex_alu_operation), 32'(ALU_ADD));

    // Double forward
    s = idle(); s.id_valid = 1; s.rs1a = 3; s.rs1u = 1; s.rs1d = 32'h99; s.rda = 8;
    drive(s);
    s = idle(); s.stall = 1;
    s.exm_we = 1; s.exm_rd = 3; s.exm_v = 32'h11;
    s.mwb_we = 1; s.mwb_rd = 3; s.mwb_v = 32'h22;
    drive(s);
    cmp("fwd_exm", ex_rs1_value, 32'h11);
    s.exm_we = 0;
    drive(s);
    cmp("fwd_mwb", ex_rs1_value, 32'h22);
    s = idle(); s.id_valid = 1; s.rs1a = 0; s.rs1d = 0; s.rs1u = 1;
    drive(s);
    s = idle(); s.stall = 1;
    s.exm_we = 1; s.exm_rd = 0; s.exm_v = 32'h11;
    s.mwb_we = 1; s.mwb_rd = 0; s.mwb_v = 32'h22;
    drive(s);
    cmp("fwd_x0", ex_rs1_value, 32'd0);

    // Load-use
    s = idle(); s.id_valid = 1; s.mr = 1; s.rw = 1; s.rda = 4;
    drive(s);
    h = idle(); h.id_valid = 1; h.rs2a = 4; h.rs2u = 1; h.rs1a = 1; h.rs1u = 1;
    h.rda = 5; h.op = ALU_SUB; h.pc = 32'h200; h.rw = 1;
    drive(h);
    cmp("lu_hazard", 32'(load_use_hazard), 32'd1);
    cmp("lu_ready", 32'(id_bus.ready), 32'd0);
    drive(h);
    cmp("lu_bubble", 32'(ex_valid), 32'd0);
    drive(idle());
    cmp("lu_issue_valid", 32'(ex_valid), 32'd1);
    cmp("lu_issue_pc", ex_pc, 32'h200);

    // Immediate / PC select
    s = idle(); s.id_valid = 1; s.use_imm = 1; s.imm = 32'hFFFF_FFFC; s.rs2a = 6;
    s.rs2u = 1; s.rs2d = 32'h3; s.use_pc = 1; s.pc = 32'h100; s.rs1a = 7; s.rs1u = 1;
    drive(s);
    s = idle(); s.exm_we = 1; s.exm_rd = 6; s.exm_v = 32'h9;
    drive(s);
    cmp("imm_rs2", ex_rs2_value, 32'hFFFF_FFFC);
    cmp("imm_store", ex_store_data, 32'h9);
    cmp("pc_rs1", ex_rs1_value, 32'h100);

    // Stall then flush
    s = idle(); s.id_valid = 1; s.pc = 32'h300; s.op = ALU_XOR; s.rda = 2;
    drive(s);
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.stall = 1; s.flush = 0; s.rst = 0;
      drive(s);
      cmp("stall_pc", ex_pc, 32'h300);
      cmp("stall_op", 32'(ex_alu_operation), 32'(ALU_XOR));
    end
    s = idle(); s.stall = 1; s.flush = 1;
    drive(s);
    drive(idle());
    cmp("flush_valid", 32'(ex_valid), 32'd0);

    // Reset mid-stall
    s = idle(); s.id_valid = 1; s.op = ALU_SUB; s.rw = 1; s.mr = 1; s.mw = 1;
    s.pc = 32'h500; s.rda = 9;
    drive(s);
    s = idle(); s.stall = 1; s.rst = 1;
    drive(s);
    drive(idle());
    cmp("rst_valid", 32'(ex_valid), 32'd0);
    cmp("rst_flags", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    cmp("rst_op", 32'(ex_alu_operation), 32'(ALU_ADD));

    // Randomized traffic
    for (int i = 0; i < 2000; i++) drive(rand_stim());

    @(negedge clk);
    #3;
    cmp("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
